// File: rtl/out_writer_pkg.sv
// Shared types and constants for the output tile writer: FSM encoding,
// default geometry, and the tile-base address step used by the serialiser.
package out_writer_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_BLOCK_SIZE = 2;
  localparam int DEF_ROW_SIZE   = 3;
  localparam int DEF_COL_SIZE   = 3;
  localparam int ROW_WORDS      = DEF_BLOCK_SIZE * DEF_COL_SIZE;
  localparam int TILE_W         = DEF_WIDTH * DEF_BLOCK_SIZE * DEF_BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Increment from the row-0 word of one tile to the row-0 word of the next
  // tile in row-major tile order; the last tile column wraps to the next tile row.
  function automatic int tile_base_step(input logic last_col, input int col_size,
                                        input int row_words);
    return last_col ? (row_words - col_size + 1) : 1;
  endfunction

endpackage

// File: rtl/out_tile_writer_tile_fifo.sv
// Synchronous tile FIFO with registered full/empty; head is visible combinationally.
// Pop data is valid whenever empty is low; push is ignored when full.
module tile_fifo
  import out_writer_pkg::*;
#(
  parameter int WIDTH = TILE_W,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;

  assign w_push   = i_push && !r_full;
  assign w_pop    = i_pop && !r_empty;
  assign w_wr_nxt = r_wr_ptr + (AW + 1)'(w_push);
  assign w_rd_nxt = r_rd_ptr + (AW + 1)'(w_pop);

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      r_full   <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) && (w_wr_nxt[AW] != w_rd_nxt[AW]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/out_tile_writer.sv
// Buffers finished C tiles and writes each as BLOCK_SIZE row segments to the output BRAM.
// First write one cycle after the push edge; bram_gnt low stalls the row, a full FIFO drops tiles.
module out_tile_writer
  import out_writer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter int CHUNK_SIZE     = DEF_BLOCK_SIZE * DEF_BLOCK_SIZE,
  parameter int ROW_SIZE_MAT_C = DEF_ROW_SIZE,
  parameter int COL_SIZE_MAT_C = DEF_COL_SIZE,
  parameter int MAX_FLAG       = ROW_SIZE_MAT_C * COL_SIZE_MAT_C,
  parameter int ADDR_WIDTH     = 12,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_tile_valid,
  input  logic [WIDTH*CHUNK_SIZE-1:0]   i_tile_data,
  output logic                          o_tile_ready,
  output logic                          o_bram_en,
  output logic [WIDTH*BLOCK_SIZE/8-1:0] o_bram_we,
  output logic [ADDR_WIDTH-1:0]         o_bram_addr,
  output logic [WIDTH*BLOCK_SIZE-1:0]   o_bram_din,
  input  logic                          i_bram_gnt,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_overflow
);
  localparam int TILE_BITS = WIDTH * CHUNK_SIZE;
  localparam int SEG_BITS  = WIDTH * BLOCK_SIZE;
  localparam int SEG_ROWS  = BLOCK_SIZE * COL_SIZE_MAT_C;
  localparam int CNT_W     = $clog2(MAX_FLAG + 1);
  localparam int ROW_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int COL_W     = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_acc_cnt;
  logic [CNT_W-1:0]       r_wr_cnt;
  logic                   r_ser_vld;
  logic [TILE_BITS-1:0]   r_ser_tile;
  logic [ROW_W-1:0]       r_row;
  logic [COL_W-1:0]       r_tile_col;
  logic [ADDR_WIDTH-1:0]  r_tile_base;
  logic [ADDR_WIDTH-1:0]  r_addr;

  logic                   w_active;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [TILE_BITS-1:0]   w_fifo_dat;
  logic                   w_room;
  logic                   w_tile_ready;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_row_done;
  logic                   w_last_row;
  logic                   w_last_col;
  logic                   w_tile_done;
  logic                   w_pop;
  logic                   w_final;
  logic [ADDR_WIDTH-1:0]  w_next_base;
  logic [SEG_BITS-1:0]    w_seg;

  assign w_active     = (r_state == ACTIVE);
  assign w_room       = (r_acc_cnt < CNT_W'(MAX_FLAG));
  assign w_tile_ready = w_active && !w_fifo_full && w_room;
  assign w_push       = i_tile_valid && w_tile_ready;
  assign w_drop       = w_active && i_tile_valid && !w_tile_ready && w_room;

  assign w_row_done   = r_ser_vld && i_bram_gnt;
  assign w_last_row   = (r_row == ROW_W'(BLOCK_SIZE - 1));
  assign w_last_col   = (r_tile_col == COL_W'(COL_SIZE_MAT_C - 1));
  assign w_tile_done  = w_row_done && w_last_row;
  // Reload on the last row's grant so consecutive tiles stream without a bubble.
  assign w_pop        = w_active && !w_fifo_empty && (!r_ser_vld || w_tile_done);
  assign w_final      = w_tile_done && (r_wr_cnt == CNT_W'(MAX_FLAG - 1));
  assign w_next_base  = ADDR_WIDTH'(int'(r_tile_base)
                        + tile_base_step(w_last_col, COL_SIZE_MAT_C, SEG_ROWS));
  assign w_seg        = r_ser_tile[int'(r_row)*SEG_BITS +: SEG_BITS];

  tile_fifo #(
    .WIDTH (TILE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat (i_tile_data),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_acc_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_ser_vld   <= 1'b0;
      r_ser_tile  <= '0;
      r_row       <= '0;
      r_tile_col  <= '0;
      r_tile_base <= '0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state     <= ACTIVE;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_ser_vld   <= 1'b0;
            r_row       <= '0;
            r_tile_col  <= '0;
            r_tile_base <= '0;
            r_addr      <= '0;
          end
        end
        ACTIVE: begin
          if (w_push) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
          if (w_drop) r_overflow <= 1'b1;
          if (w_row_done) begin
            if (w_last_row) begin
              r_row       <= '0;
              r_wr_cnt    <= r_wr_cnt + CNT_W'(1);
              r_tile_col  <= w_last_col ? '0 : r_tile_col + COL_W'(1);
              r_tile_base <= w_next_base;
              r_addr      <= w_next_base;
            end else begin
              r_row  <= r_row + ROW_W'(1);
              r_addr <= r_addr + ADDR_WIDTH'(COL_SIZE_MAT_C);
            end
          end
          if (w_pop) begin
            r_ser_vld  <= 1'b1;
            r_ser_tile <= w_fifo_dat;
          end else if (w_tile_done) begin
            r_ser_vld  <= 1'b0;
          end
          if (w_final) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tile_ready = w_tile_ready;
  assign o_bram_en    = r_ser_vld;
  assign o_bram_we    = {(WIDTH*BLOCK_SIZE/8){r_ser_vld}};
  assign o_bram_addr  = r_ser_vld ? r_addr : '0;
  assign o_bram_din   = r_ser_vld ? w_seg : '0;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;

endmodule
